// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for a simple shooter.
// Tracks level, lives, living-enemy mask and a saturating kill score, and
// paces the level-clear / life-lost pauses on VGA frame ticks.
//
// Ports:
//   pclk       - pixel clock, all logic on its rising edge
//   rst        - asynchronous active-low reset
//   vsync_in   - VGA vsync (pclk domain); each rising edge is one frame tick
//   start      - debounced start/fire button; only its rising edge acts
//   enemy_hit  - per-enemy one-cycle hit pulses
//   ship_hit   - one-cycle player-hit pulse
//   level      - current level, 1..MAX_LEVEL
//   lives      - remaining lives
//   alive      - mask of living enemies
//   score      - saturating kill count
//   state      - FSM state code (IDLE=0 PLAY=1 CLEAR=2 LOST=3 OVER=4 WIN=5)
//   freeze     - high whenever state is not PLAY
module game_ctrl #(
  parameter int unsigned NUM_ENEMIES  = 3,
  parameter int unsigned MAX_LEVEL    = 4,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned SCORE_W      = 12
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   vsync_in,
  input  logic                   start,
  input  logic [NUM_ENEMIES-1:0] enemy_hit,
  input  logic                   ship_hit,
  output logic [3:0]             level,
  output logic [3:0]             lives,
  output logic [NUM_ENEMIES-1:0] alive,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             state,
  output logic                   freeze
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CLEAR = 3'd2,
    S_LOST  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  localparam int unsigned          SUM_W      = SCORE_W + 5;
  localparam logic [3:0]           LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [3:0]           LIVES_INIT = 4'(LIVES);
  localparam logic [7:0]           PAUSE_CNT  = 8'(PAUSE_FRAMES);
  localparam logic [NUM_ENEMIES-1:0] ALL_ALIVE = '1;
  localparam logic [SCORE_W-1:0]   SCORE_MAX  = '1;

  state_e                   state_q, state_d;
  logic [3:0]               level_q, level_d;
  logic [3:0]               lives_q, lives_d;
  logic [NUM_ENEMIES-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic [7:0]               frame_q, frame_d;
  logic                     vsync_prev_q, vsync_prev_d;
  logic                     start_prev_q, start_prev_d;
  logic                     ready_q, ready_d;
  logic                     freeze_q, freeze_d;

  logic                     tick;
  logic                     start_rise;
  logic [NUM_ENEMIES-1:0]   valid_hit;
  logic [4:0]               hit_cnt;
  logic [SUM_W-1:0]         score_sum;
  logic [SCORE_W-1:0]       score_sat;
  logic [7:0]               frame_inc;

  always_comb begin
    tick       = vsync_in & ~vsync_prev_q;
    start_rise = start & ~start_prev_q;
    valid_hit  = enemy_hit & alive_q;
    hit_cnt    = '0;
    for (int unsigned i = 0; i < NUM_ENEMIES; i++) begin
      hit_cnt = hit_cnt + 5'(valid_hit[i]);
    end
    score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
    score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    frame_inc = frame_q + 8'd1;
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    alive_d      = alive_q;
    score_d      = score_q;
    frame_d      = frame_q;
    vsync_prev_d = vsync_in;
    start_prev_d = start;
    ready_d      = 1'b1;

    // The first edge after reset release only primes the edge detectors, so
    // a start button held through deassertion is not seen as a press.
    if (ready_q) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_rise) state_d = S_PLAY;
        end

        S_PLAY: begin
          alive_d = alive_q & ~valid_hit;
          score_d = score_sat;
          if (ship_hit) begin
            lives_d = lives_q - 4'd1;
            frame_d = '0;
            state_d = (lives_q == 4'd1) ? S_OVER : S_LOST;
          end else if ((|enemy_hit) && (alive_d == '0)) begin
            // Only a hit pulse re-evaluates the mask, so returning from LOST
            // with no enemies left waits for the next hit before clearing.
            frame_d = '0;
            state_d = S_CLEAR;
          end
        end

        S_CLEAR, S_LOST: begin
          if (tick) begin
            frame_d = frame_inc;
            if (frame_inc == PAUSE_CNT) begin
              frame_d = '0;
              if (state_q == S_LOST) begin
                state_d = S_PLAY;
              end else if (level_q == LEVEL_MAX) begin
                state_d = S_WIN;
              end else begin
                level_d = level_q + 4'd1;
                alive_d = ALL_ALIVE;
                state_d = S_PLAY;
              end
            end
          end
        end

        S_OVER, S_WIN: begin
          if (start_rise) begin
            state_d = S_IDLE;
            level_d = 4'd1;
            lives_d = LIVES_INIT;
            alive_d = ALL_ALIVE;
            score_d = '0;
            frame_d = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      level_q      <= 4'd1;
      lives_q      <= LIVES_INIT;
      alive_q      <= ALL_ALIVE;
      score_q      <= '0;
      frame_q      <= '0;
      vsync_prev_q <= 1'b0;
      start_prev_q <= 1'b0;
      ready_q      <= 1'b0;
      freeze_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      alive_q      <= alive_d;
      score_q      <= score_d;
      frame_q      <= frame_d;
      vsync_prev_q <= vsync_prev_d;
      start_prev_q <= start_prev_d;
      ready_q      <= ready_d;
      freeze_q     <= freeze_d;
    end
  end

  assign level  = level_q;
  assign lives  = lives_q;
  assign alive  = alive_q;
  assign score  = score_q;
  assign state  = state_q;
  assign freeze = freeze_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl with NUM_ENEMIES=3, MAX_LEVEL=2, LIVES=2, PAUSE_FRAMES=2.
// A second instance with SCORE_W=2 shares all inputs to observe saturation.
module tb_game_ctrl;

  localparam int M_IDLE = 0, M_PLAY = 1, M_CLEAR = 2, M_LOST = 3, M_OVER = 4, M_WIN = 5;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       start;
  logic [2:0] enemy_hit;
  logic       ship_hit;

  logic [3:0]  level, lives;
  logic [2:0]  alive;
  logic [11:0] score;
  logic [2:0]  state;
  logic        freeze;

  logic [3:0] s_level, s_lives;
  logic [2:0] s_alive;
  logic [1:0] s_score;
  logic [2:0] s_state;
  logic       s_freeze;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  game_ctrl #(.NUM_ENEMIES(3), .MAX_LEVEL(2), .LIVES(2), .PAUSE_FRAMES(2), .SCORE_W(12)) u_dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start), .enemy_hit(enemy_hit),
    .ship_hit(ship_hit), .level(level), .lives(lives), .alive(alive), .score(score),
    .state(state), .freeze(freeze)
  );

  game_ctrl #(.NUM_ENEMIES(3), .MAX_LEVEL(2), .LIVES(2), .PAUSE_FRAMES(2), .SCORE_W(2)) u_sat (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .start(start), .enemy_hit(enemy_hit),
    .ship_hit(ship_hit), .level(s_level), .lives(s_lives), .alive(s_alive), .score(s_score),
    .state(s_state), .freeze(s_freeze)
  );

  // ---------------- reference model (game rules, plain integers) ----------
  int m_state, m_level, m_lives, m_alive, m_kills, m_frames;
  bit m_ready, m_st_prev, m_vs_prev;

  function automatic void model_reset();
    m_state = M_IDLE; m_level = 1; m_lives = 2; m_alive = 7;
    m_kills = 0; m_frames = 0; m_ready = 0; m_st_prev = 0; m_vs_prev = 0;
  endfunction

  function automatic void model_step(bit st, bit vs, int hit, bit sh);
    bit press, tick_m;
    int landed;
    press  = st && !m_st_prev;
    tick_m = vs && !m_vs_prev;
    m_st_prev = st;
    m_vs_prev = vs;
    if (!m_ready) begin
      m_ready = 1;
      return;
    end
    case (m_state)
      M_IDLE: if (press) m_state = M_PLAY;
      M_PLAY: begin
        landed  = hit & m_alive;
        m_kills = m_kills + $countones(landed);
        m_alive = m_alive & ~landed & 7;
        if (sh) begin
          m_lives  = m_lives - 1;
          m_frames = 0;
          m_state  = (m_lives == 0) ? M_OVER : M_LOST;
        end else if (hit != 0 && m_alive == 0) begin
          m_frames = 0;
          m_state  = M_CLEAR;
        end
      end
      M_CLEAR, M_LOST: if (tick_m) begin
        m_frames++;
        if (m_frames == 2) begin
          m_frames = 0;
          if (m_state == M_LOST) m_state = M_PLAY;
          else if (m_level == 2) m_state = M_WIN;
          else begin
            m_level++; m_alive = 7; m_state = M_PLAY;
          end
        end
      end
      default: if (press) begin
        m_state = M_IDLE; m_level = 1; m_lives = 2; m_alive = 7; m_kills = 0;
      end
    endcase
  endfunction

  // ---------------- checking ----------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_state, input int e_level,
                           input int e_lives, input int e_alive, input int e_score);
    check({tag, " state"},  32'(state),  32'(e_state));
    check({tag, " level"},  32'(level),  32'(e_level));
    check({tag, " lives"},  32'(lives),  32'(e_lives));
    check({tag, " alive"},  32'(alive),  32'(e_alive));
    check({tag, " freeze"}, 32'(freeze), 32'(e_state != M_PLAY));
    check({tag, " score"},  32'(score),  32'(e_score > 4095 ? 4095 : e_score));
    check({tag, " sat_score"}, 32'(s_score), 32'(e_score > 3 ? 3 : e_score));
    check({tag, " sat_other"}, 32'({s_state, s_level, s_lives, s_alive, s_freeze}),
          32'({3'(e_state), 4'(e_level), 4'(e_lives), 3'(e_alive), e_state != M_PLAY}));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_state, m_level, m_lives, m_alive, m_kills);
  endtask

  task automatic cycle(input bit st, input bit vs, input logic [2:0] hit, input bit sh);
    @(negedge pclk);
    start = st; vsync_in = vs; enemy_hit = hit; ship_hit = sh;
    @(posedge pclk);
    model_step(st, vs, int'(hit), sh);
    #1;
  endtask

  task automatic release_rst(input bit st);
    @(negedge pclk);
    rst = 1'b1; start = st; vsync_in = 1'b0; enemy_hit = '0; ship_hit = 1'b0;
    @(posedge pclk);
    model_step(st, 1'b0, 0, 1'b0);
    #1;
  endtask

  typedef struct {
    bit st; bit vs; logic [2:0] hit; bit sh;
    int e_state; int e_level; int e_lives; int e_alive; int e_score;
  } vec_t;

  vec_t tbl[36];

  initial begin
    // {start, vsync, enemy_hit, ship_hit, state, level, lives, alive, score}
    tbl[0]  = '{1,0,3'd0,0, 1,1,2,7,0};  // start edge -> PLAY
    tbl[1]  = '{0,0,3'd3,0, 1,1,2,4,2};
    tbl[2]  = '{0,0,3'd4,0, 2,1,2,0,3};  // last kill -> CLEAR
    tbl[3]  = '{0,1,3'd7,0, 2,1,2,0,3};  // hits ignored in CLEAR
    tbl[4]  = '{1,0,3'd0,0, 2,1,2,0,3};  // start ignored in CLEAR
    tbl[5]  = '{0,1,3'd0,0, 1,2,2,7,3};  // second frame -> level 2
    tbl[6]  = '{0,0,3'd1,0, 1,2,2,6,4};
    tbl[7]  = '{0,0,3'd0,0, 1,2,2,6,4};
    tbl[8]  = '{0,0,3'd1,0, 1,2,2,6,4};  // dead enemy hit ignored
    tbl[9]  = '{0,0,3'd6,1, 3,2,1,0,6};  // ship hit with last kill -> LOST
    tbl[10] = '{0,1,3'd0,0, 3,2,1,0,6};
    tbl[11] = '{0,0,3'd0,0, 3,2,1,0,6};
    tbl[12] = '{0,1,3'd0,0, 1,2,1,0,6};  // back to PLAY, mask empty
    tbl[13] = '{0,0,3'd0,0, 1,2,1,0,6};  // no re-evaluation without a hit
    tbl[14] = '{1,0,3'd0,0, 1,2,1,0,6};  // start ignored in PLAY
    tbl[15] = '{0,0,3'd0,1, 4,2,0,0,6};  // last life -> OVER
    tbl[16] = '{0,1,3'd0,0, 4,2,0,0,6};
    tbl[17] = '{1,0,3'd0,0, 0,1,2,7,0};  // OVER -> IDLE, counters reset
    tbl[18] = '{0,0,3'd0,0, 0,1,2,7,0};
    tbl[19] = '{1,0,3'd0,0, 1,1,2,7,0};  // new game
    tbl[20] = '{0,0,3'd1,0, 1,1,2,6,1};
    tbl[21] = '{0,0,3'd0,1, 3,1,1,6,1};  // LOST, alive unchanged
    tbl[22] = '{0,1,3'd0,0, 3,1,1,6,1};
    tbl[23] = '{0,0,3'd0,0, 3,1,1,6,1};
    tbl[24] = '{0,1,3'd0,0, 1,1,1,6,1};
    tbl[25] = '{0,0,3'd6,0, 2,1,1,0,3};
    tbl[26] = '{0,1,3'd0,0, 2,1,1,0,3};
    tbl[27] = '{0,0,3'd0,0, 2,1,1,0,3};
    tbl[28] = '{0,1,3'd0,0, 1,2,1,7,3};
    tbl[29] = '{0,0,3'd7,0, 2,2,1,0,6};  // small score saturates here
    tbl[30] = '{0,1,3'd0,0, 2,2,1,0,6};
    tbl[31] = '{0,0,3'd0,0, 2,2,1,0,6};
    tbl[32] = '{0,1,3'd0,0, 5,2,1,0,6};  // CLEAR at max level -> WIN
    tbl[33] = '{0,0,3'd7,1, 5,2,1,0,6};  // inputs ignored in WIN
    tbl[34] = '{1,0,3'd0,0, 0,1,2,7,0};  // WIN -> IDLE
    tbl[35] = '{0,0,3'd0,0, 0,1,2,7,0};

    rst = 1'b0; start = 1'b0; vsync_in = 1'b0; enemy_hit = '0; ship_hit = 1'b0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    check_all("reset", M_IDLE, 1, 2, 7, 0);
    release_rst(1'b0);
    check_all("release", M_IDLE, 1, 2, 7, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].st, tbl[i].vs, tbl[i].hit, tbl[i].sh);
      check_all($sformatf("row%0d", i), tbl[i].e_state, tbl[i].e_level,
                tbl[i].e_lives, tbl[i].e_alive, tbl[i].e_score);
    end

    for (int n = 0; n < 3000; n++) begin
      bit st, vs, sh;
      logic [2:0] hit;
      st  = ($urandom % 6) == 0;
      vs  = $urandom_range(0, 1) == 1;
      hit = (($urandom % 3) == 0) ? 3'($urandom) : 3'd0;
      sh  = ($urandom % 25) == 0;
      cycle(st, vs, hit, sh);
      check_model($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of a CLEAR pause.
    @(negedge pclk);
    rst = 1'b0;
    model_reset();
    #1;
    release_rst(1'b0);
    cycle(1, 0, 3'd0, 0);
    cycle(0, 0, 3'd7, 0);
    check_model("pre_clear");
    cycle(0, 1, 3'd0, 0);
    check_model("mid_clear");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst", M_IDLE, 1, 2, 7, 0);

    // Start held high across reset release must not register a press.
    start = 1'b1;
    release_rst(1'b1);
    check_all("held_release", M_IDLE, 1, 2, 7, 0);
    cycle(1, 0, 3'd0, 0);
    check_all("held_start", M_IDLE, 1, 2, 7, 0);
    cycle(0, 0, 3'd0, 0);
    cycle(1, 0, 3'd0, 0);
    check_all("fresh_start", M_PLAY, 1, 2, 7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
